hazard_stall_ctrl: RTL and testbench

- Stall/flush controller for the 5-stage MIPS pipeline; the consumer-side counterpart of the EX-stage forwarding unit.
- Handles the hazards forwarding cannot resolve:
  - load-use on the ID-stage instruction;
  - ID-stage reads of HI/LO, or a new mult/div, while the multi-cycle mult/div unit is busy.
- Also generates IF/ID flush for taken branches and jumps resolved in ID.
- Drives PC, IF/ID and ID/EX write-enable/flush controls.

---
 rtl/hazard_stall_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/flush controller for the 5-stage MIPS pipeline.
// Covers the hazards the EX forwarding unit cannot resolve:
//   - load-use on the ID instruction;
//   - ID HI/LO reads or a new mult/div while the multi-cycle unit is busy.
// It also flushes IF/ID for taken branches and jumps that are resolved in ID.
// Optional: define HAZARD_STALL_STATS_EN to add the stall_cycles and
// flush_cycles saturating event counters.
module hazard_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_IF_ID,
    input  logic [4:0] rt_IF_ID,
    input  logic       ID_uses_rs,
    input  logic       ID_uses_rt,
    input  logic       ID_md_read,
    input  logic       ID_md_op,
    input  logic [4:0] rt_ID_EX_r,
    input  logic       EX_ctrl_MemRd,
    input  logic       EX_md_start,
    input  logic       EX_md_div,
    input  logic       ID_branch_taken,
    input  logic       ID_jump,
    output logic       PC_wr_en,
    output logic       IF_ID_wr_en,
    output logic       IF_ID_flush,
    output logic       ID_EX_flush,
    output logic       md_busy
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);

    typedef enum logic {RUN, MD_BUSY} state_t;

    // The start cycle is already busy, so the counter holds the remaining LAT-1 cycles.
    localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_t           stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             loadHz, mdHz, stall, mdBusyRaw, lastBusy, flushRaw;

    // State and busy-counter register. On reset the pending HI/LO result is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= RUN;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    // Next-state logic and the combinational hazard/stall outputs.
    always_comb begin
        stateD      = stateQ;
        cntD        = cntQ;
        PC_wr_en    = 1'b1;
        IF_ID_wr_en = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        md_busy     = 1'b0;

        case (stateQ)
            RUN: begin
                if (EX_md_start) begin
                    stateD = MD_BUSY;
                    cntD   = EX_md_div ? DivLoad : MulLoad;
                end
            end
            MD_BUSY: begin
                // A start here is impossible because ID is stalled. It is ignored and does not reload.
                if (cntQ <= CntOne) begin
                    stateD = RUN;
                    cntD   = '0;
                end else begin
                    cntD = cntQ - CntOne;
                end
            end
            default: begin
                stateD = RUN;
                cntD   = '0;
            end
        endcase

        mdBusyRaw = (stateQ == MD_BUSY) || EX_md_start;
        // On the final busy cycle the result is ready at the next edge, so no stall is needed.
        lastBusy  = (stateQ == MD_BUSY) && (cntQ == CntOne);
        loadHz    = EX_ctrl_MemRd && (rt_ID_EX_r != 5'd0) &&
                    ((ID_uses_rs && (rs_IF_ID == rt_ID_EX_r)) ||
                     (ID_uses_rt && (rt_IF_ID == rt_ID_EX_r)));
        mdHz      = mdBusyRaw && (ID_md_read || ID_md_op) && !lastBusy;
        stall     = loadHz || mdHz;
        // The branch decision is not valid while stalled; it is re-evaluated on release.
        flushRaw  = (ID_branch_taken || ID_jump) && !stall;

        if (!rst) begin
            PC_wr_en    = 1'b0;
            IF_ID_wr_en = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            md_busy     = 1'b0;
        end else begin
            PC_wr_en    = !stall;
            IF_ID_wr_en = !stall;
            IF_ID_flush = flushRaw;
            ID_EX_flush = stall;
            md_busy     = mdBusyRaw;
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    // Saturating event counters. Only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (flushRaw && (flush_cycles != 32'hFFFF_FFFF))
                flush_cycles <= flush_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl. It runs directed scenarios with literal
// expectations, then a randomized phase. A behavioural model checks every cycle.
module tb_hazard_stall_ctrl;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_IF_ID, rt_IF_ID, rt_ID_EX_r;
    logic       ID_uses_rs, ID_uses_rt, ID_md_read, ID_md_op;
    logic       EX_ctrl_MemRd, EX_md_start, EX_md_div, ID_branch_taken, ID_jump;
    logic       PC_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_flush, md_busy;
`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    int nChecks = 0;
    int nFail   = 0;
    int mRemain = 0;   // model: busy cycles left at the start of the current cycle
`ifdef HAZARD_STALL_STATS_EN
    longint mStall = 0, mFlush = 0;
`endif

    hazard_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .rs_IF_ID(rs_IF_ID), .rt_IF_ID(rt_IF_ID),
        .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .ID_md_read(ID_md_read), .ID_md_op(ID_md_op),
        .rt_ID_EX_r(rt_ID_EX_r), .EX_ctrl_MemRd(EX_ctrl_MemRd),
        .EX_md_start(EX_md_start), .EX_md_div(EX_md_div),
        .ID_branch_taken(ID_branch_taken), .ID_jump(ID_jump),
        .PC_wr_en(PC_wr_en), .IF_ID_wr_en(IF_ID_wr_en),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .md_busy(md_busy)
`ifdef HAZARD_STALL_STATS_EN
        , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model and per-cycle compare. Inputs change only just after posedge, so negedge sees this cycle's values.
    always @(negedge clk) begin
        int  curLeft;
        bit  eLoad, eMd, eStall, eBusy, eFlush;
        if (!rst) begin
            chk("rst_PC_wr_en", PC_wr_en, 0);
            chk("rst_IF_ID_wr_en", IF_ID_wr_en, 0);
            chk("rst_IF_ID_flush", IF_ID_flush, 1);
            chk("rst_ID_EX_flush", ID_EX_flush, 1);
            chk("rst_md_busy", md_busy, 0);
            mRemain = 0;
`ifdef HAZARD_STALL_STATS_EN
            mStall = 0; mFlush = 0;
            chk("rst_stall_cycles", stall_cycles, 0);
            chk("rst_flush_cycles", flush_cycles, 0);
`endif
        end else begin
            if (mRemain > 0 && EX_md_start)
                chk("start_while_busy", 1, 0);
            curLeft = (mRemain == 0 && EX_md_start) ? (EX_md_div ? DIV_LAT : MUL_LAT) : mRemain;
            eBusy   = curLeft > 0;
            eLoad   = EX_ctrl_MemRd && rt_ID_EX_r != 0 &&
                      ((ID_uses_rs && rs_IF_ID == rt_ID_EX_r) || (ID_uses_rt && rt_IF_ID == rt_ID_EX_r));
            eMd     = eBusy && (ID_md_read || ID_md_op) && curLeft != 1;
            eStall  = eLoad || eMd;
            eFlush  = (ID_branch_taken || ID_jump) && !eStall;
            chk("PC_wr_en", PC_wr_en, !eStall);
            chk("IF_ID_wr_en", IF_ID_wr_en, !eStall);
            chk("ID_EX_flush", ID_EX_flush, eStall);
            chk("IF_ID_flush", IF_ID_flush, eFlush);
            chk("md_busy", md_busy, eBusy);
`ifdef HAZARD_STALL_STATS_EN
            chk("stall_cycles", stall_cycles, mStall);
            chk("flush_cycles", flush_cycles, mFlush);
            if (eStall && mStall < 64'hFFFF_FFFF) mStall++;
            if (eFlush && mFlush < 64'hFFFF_FFFF) mFlush++;
`endif
            mRemain = eBusy ? curLeft - 1 : 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_IF_ID = 0; rt_IF_ID = 0; rt_ID_EX_r = 0;
        ID_uses_rs = 0; ID_uses_rt = 0; ID_md_read = 0; ID_md_op = 0;
        EX_ctrl_MemRd = 0; EX_md_start = 0; EX_md_div = 0;
        ID_branch_taken = 0; ID_jump = 0;
    endtask

    initial begin
        int stallCnt, busyCnt;
        rst = 1'b0;
        idle();
        cyc(); cyc();
        #2;
        chk("lit_reset_PC_wr_en", PC_wr_en, 0);
        chk("lit_reset_IF_ID_flush", IF_ID_flush, 1);
        cyc();
        rst = 1'b1;
        cyc();

        // Load-use: one stall cycle, then release
        EX_ctrl_MemRd = 1; rt_ID_EX_r = 8; rs_IF_ID = 8; ID_uses_rs = 1;
        #2;
        chk("lit_lu_PC_wr_en", PC_wr_en, 0);
        chk("lit_lu_IF_ID_wr_en", IF_ID_wr_en, 0);
        chk("lit_lu_ID_EX_flush", ID_EX_flush, 1);
        cyc();
        EX_ctrl_MemRd = 0;
        #2;
        chk("lit_lu_release", {PC_wr_en, IF_ID_wr_en, ID_EX_flush}, 3'b110);
        cyc();
        EX_ctrl_MemRd = 1; rt_ID_EX_r = 0; rs_IF_ID = 0;
        #2;
        chk("lit_lu_r0", PC_wr_en, 1);
        cyc();
        rt_ID_EX_r = 8; rs_IF_ID = 8; ID_uses_rs = 0;
        #2;
        chk("lit_lu_nouse", PC_wr_en, 1);
        cyc();
        idle();

        // Divide with mflo waiting: 31 stalls, and md_busy is still high on the release cycle
        EX_md_start = 1; EX_md_div = 1; ID_md_read = 1;
        stallCnt = 0;
        for (int k = 0; k < 40; k++) begin
            #2;
            if (PC_wr_en) break;
            stallCnt++;
            cyc();
            EX_md_start = 0;
        end
        chk("lit_div_stalls", stallCnt, 31);
        chk("lit_div_busy_last", md_busy, 1);
        cyc();
        ID_md_read = 0;
        #2;
        chk("lit_div_done", md_busy, 0);
        cyc();

        // Mult followed by a back-to-back mult: 3 stalls, then a reload gives 4 busy cycles
        EX_md_start = 1; EX_md_div = 0; ID_md_op = 1;
        stallCnt = 0;
        for (int k = 0; k < 10; k++) begin
            #2;
            if (PC_wr_en) break;
            stallCnt++;
            cyc();
            EX_md_start = 0;
        end
        chk("lit_mul_stalls", stallCnt, 3);
        cyc();
        EX_md_start = 1; ID_md_op = 0;
        busyCnt = 0;
        for (int k = 0; k < 10; k++) begin
            #2;
            if (!md_busy) break;
            busyCnt++;
            cyc();
            EX_md_start = 0;
        end
        chk("lit_mul_reload_busy", busyCnt, MUL_LAT);
        cyc();

        // Branch flush, with and without a load-use stall
        ID_branch_taken = 1;
        #2;
        chk("lit_br_flush", IF_ID_flush, 1);
        cyc();
        EX_ctrl_MemRd = 1; rt_ID_EX_r = 5; rt_IF_ID = 5; ID_uses_rt = 1;
        #2;
        chk("lit_br_stall_noflush", IF_ID_flush, 0);
        cyc();
        EX_ctrl_MemRd = 0;
        #2;
        chk("lit_br_release_flush", IF_ID_flush, 1);
        cyc();
        idle();

        // Reset in the middle of a divide (after 22 edges cnt==10)
        EX_md_start = 1; EX_md_div = 1;
        cyc();
        EX_md_start = 0;
        for (int k = 0; k < 21; k++) cyc();
        #2;
        chk("lit_mid_busy", md_busy, 1);
        cyc();
        rst = 1'b0;
        #2;
        chk("lit_midrst_busy", md_busy, 0);
        chk("lit_midrst_en", {PC_wr_en, IF_ID_wr_en}, 2'b00);
        cyc();
        rst = 1'b1; ID_md_read = 1;
        #2;
        chk("lit_postrst_nostall", PC_wr_en, 1);
        chk("lit_postrst_busy", md_busy, 0);
        cyc();
        idle();

        // Random phase. Starts are issued only while the model says the unit is idle.
        for (int c = 0; c < 4000; c++) begin
            rs_IF_ID        = 5'($urandom_range(0, 3));
            rt_IF_ID        = 5'($urandom_range(0, 3));
            rt_ID_EX_r      = 5'($urandom_range(0, 3));
            ID_uses_rs      = 1'($urandom);
            ID_uses_rt      = 1'($urandom);
            ID_md_read      = ($urandom_range(0, 3) == 0);
            ID_md_op        = ($urandom_range(0, 5) == 0);
            EX_ctrl_MemRd   = ($urandom_range(0, 2) == 0);
            EX_md_div       = ($urandom_range(0, 3) == 0);
            EX_md_start     = (rst && mRemain == 0 && $urandom_range(0, 7) == 0);
            ID_branch_taken = ($urandom_range(0, 3) == 0);
            ID_jump         = ($urandom_range(0, 7) == 0);
            if (rst && $urandom_range(0, 299) == 0) rst = 1'b0;
            else rst = 1'b1;
            cyc();
        end
        idle();
        cyc(); cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
